// File: rtl/top_pkg.sv
// Shared constants for the two-digit BCD counter with seven-segment display.
package top_pkg;

  // Default input clock frequency in Hz.
  localparam int unsigned DefaultClkHz = 100_000_000;

  // Tick period and refresh select bit used when SIM_FAST_TICK_EN is defined.
  localparam int unsigned FastTickPeriod = 100;
  localparam int unsigned FastSelBit     = 3;

  // Active-low segment patterns, {g,f,e,d,c,b,a}.
  localparam logic [6:0] Seg0     = 7'b100_0000;
  localparam logic [6:0] Seg1     = 7'b111_1001;
  localparam logic [6:0] Seg2     = 7'b010_0100;
  localparam logic [6:0] Seg3     = 7'b011_0000;
  localparam logic [6:0] Seg4     = 7'b001_1001;
  localparam logic [6:0] Seg5     = 7'b001_0010;
  localparam logic [6:0] Seg6     = 7'b000_0010;
  localparam logic [6:0] Seg7     = 7'b111_1000;
  localparam logic [6:0] Seg8     = 7'b000_0000;
  localparam logic [6:0] Seg9     = 7'b001_0000;
  localparam logic [6:0] SegBlank = 7'b111_1111;

  // Active-low anode selects; an[7:2] are unused and held high.
  localparam logic [7:0] AnUnits = 8'b1111_1110;
  localparam logic [7:0] AnTens  = 8'b1111_1101;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD to active-low seven-segment decoder; non-BCD codes blank the digit.
module seg7_decoder
  import top_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Map each BCD code onto its segment pattern.
  always_comb begin
    seg = SegBlank;
    case (bcd)
      4'd0:    seg = Seg0;
      4'd1:    seg = Seg1;
      4'd2:    seg = Seg2;
      4'd3:    seg = Seg3;
      4'd4:    seg = Seg4;
      4'd5:    seg = Seg5;
      4'd6:    seg = Seg6;
      4'd7:    seg = Seg7;
      4'd8:    seg = Seg8;
      4'd9:    seg = Seg9;
      default: seg = SegBlank;
    endcase
  end

endmodule

// File: rtl/top.sv
// Two-digit BCD up-counter (00-99) driving a multiplexed active-low seven-segment display.
// Define SIM_FAST_TICK_EN for a 100-cycle tick period and refresh select on bit 3.
module top
  import top_pkg::*;
#(
  parameter int unsigned CLK_HZ       = DefaultClkHz,
  parameter int unsigned TICK_HZ      = 1,
  parameter int unsigned REFRESH_BITS = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] start_val,
  output logic [6:0] seg,
  output logic [7:0] an,
  output logic       dp1
);

`ifdef SIM_FAST_TICK_EN
  localparam int unsigned TickPeriod = FastTickPeriod;
  localparam int unsigned SelBit     = FastSelBit;
`else
  localparam int unsigned TickPeriod = CLK_HZ / TICK_HZ;
  localparam int unsigned SelBit     = REFRESH_BITS - 1;
`endif

  localparam int unsigned TickW = (TickPeriod > 1) ? $clog2(TickPeriod) : 1;
  localparam logic [TickW-1:0] TickLast   = TickW'(TickPeriod - 1);
  localparam logic [TickW-1:0] HalfPeriod = TickW'(TickPeriod / 2);

  logic [TickW-1:0]        tick_cnt_q, tick_cnt_d;
  logic                    tick;
  logic [3:0]              units_q, units_d;
  logic [3:0]              tens_q, tens_d;
  logic [3:0]              load_units;
  logic [REFRESH_BITS-1:0] refresh_q;
  logic                    sel;
  logic [3:0]              dec_in;
  logic [6:0]              dec_seg;
  logic [6:0]              seg_q;
  logic [7:0]              an_q;
  logic                    dp1_q;

  // Out-of-range start values load as zero.
  assign load_units = (start_val <= 4'd9) ? start_val : 4'd0;

  // Tick on the terminal count; suppressed while in reset.
  assign tick = !rst && (tick_cnt_q == TickLast);
  assign sel  = refresh_q[SelBit];

  // Next-state for the tick counter and the two BCD digits.
  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    units_d    = units_q;
    tens_d     = tens_q;
    if (tick) begin
      if (units_q >= 4'd9) begin
        units_d = 4'd0;
        tens_d  = (tens_q >= 4'd9) ? 4'd0 : tens_q + 4'd1;
      end else begin
        units_d = units_q + 4'd1;
      end
    end
  end

  // Counter state registers; reset reloads the start value every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q <= '0;
      units_q    <= load_units;
      tens_q     <= 4'd0;
      refresh_q  <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      units_q    <= units_d;
      tens_q     <= tens_d;
      refresh_q  <= refresh_q + 1'b1;
    end
  end

  // Under reset show the value being loaded so the display is valid on the first edge.
  assign dec_in = rst ? load_units : (sel ? tens_q : units_q);

  seg7_decoder u_dec (
    .bcd (dec_in),
    .seg (dec_seg)
  );

  // Registered display outputs, one cycle behind the refresh select.
  always_ff @(posedge clk) begin
    if (rst) begin
      an_q  <= AnUnits;
      seg_q <= dec_seg;
      dp1_q <= 1'b0;
    end else begin
      an_q  <= sel ? AnTens : AnUnits;
      seg_q <= dec_seg;
      dp1_q <= !(!sel && (tick_cnt_q < HalfPeriod));
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp1 = dp1_q;

endmodule

// File: tb/tb_top.sv
// Directed self-checking bench for top; a 100-cycle tick and refresh bit 3 are set through
// parameters so the expectations hold with or without SIM_FAST_TICK_EN.
module tb_top;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] start_val;
  logic [6:0] seg;
  logic [7:0] an;
  logic       dp1;

  int tests = 0;
  int fails = 0;
  int k     = 0;
  bit mon_en = 1'b0;

  top #(
    .CLK_HZ       (100),
    .TICK_HZ      (1),
    .REFRESH_BITS (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start_val (start_val),
    .seg       (seg),
    .an        (an),
    .dp1       (dp1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Advance to k = kk edges after the last reset edge.
  task automatic goto(input int kk);
    step(kk - k);
    k = kk;
  endtask

  // Anode and heartbeat invariants on every falling edge once outputs are defined.
  always @(negedge clk) begin
    if (mon_en) begin
      check("an_hi", {26'd0, an[7:2]}, 32'h3f);
      check("an_onehot", {31'd0, (an[1:0] === 2'b01) || (an[1:0] === 2'b10)}, 32'd1);
      check("dp_units_only", {31'd0, (dp1 === 1'b1) || (an[0] === 1'b0)}, 32'd1);
    end
  end

  initial begin
    // Reset resamples start_val; the last value wins.
    rst = 1'b1;
    start_val = 4'd5;
    step(1);
    mon_en = 1'b1;
    check("rst_units_first", {28'd0, dut.units_q}, 32'd5);
    start_val = 4'd3;
    step(1);
    check("rst_units", {28'd0, dut.units_q}, 32'd3);
    check("rst_tens", {28'd0, dut.tens_q}, 32'd0);
    check("rst_an", {24'd0, an}, 32'hfe);
    check("rst_seg", {25'd0, seg}, 32'b011_0000);
    check("rst_dp1", {31'd0, dp1}, 32'd0);

    // Count 03 -> 04 -> 05.
    rst = 1'b0;
    k = 0;
    goto(8);
    check("run_an_units", {24'd0, an}, 32'hfe);
    check("run_seg_3", {25'd0, seg}, 32'b011_0000);
    check("run_dp1_low", {31'd0, dp1}, 32'd0);
    goto(9);
    check("run_an_tens", {24'd0, an}, 32'hfd);
    check("run_seg_tens0", {25'd0, seg}, 32'b100_0000);
    check("run_dp1_tens", {31'd0, dp1}, 32'd1);
    goto(99);
    check("pre_tick_cnt", {25'd0, dut.tick_cnt_q}, 32'd99);
    check("pre_tick_units", {28'd0, dut.units_q}, 32'd3);
    goto(100);
    check("tick1_units", {28'd0, dut.units_q}, 32'd4);
    check("tick1_cnt", {25'd0, dut.tick_cnt_q}, 32'd0);
    goto(113);
    check("seg_4_an", {24'd0, an}, 32'hfe);
    check("seg_4", {25'd0, seg}, 32'b001_1001);
    check("seg_4_dp1", {31'd0, dp1}, 32'd0);
    goto(177);
    check("dp1_second_half_an", {24'd0, an}, 32'hfe);
    check("dp1_second_half", {31'd0, dp1}, 32'd1);
    goto(199);
    check("pre_tick2_units", {28'd0, dut.units_q}, 32'd4);
    goto(200);
    check("tick2_units", {28'd0, dut.units_q}, 32'd5);
    goto(209);
    check("seg_5", {25'd0, seg}, 32'b001_0010);

    // Mid-count reset with start_val=7.
    goto(230);
    rst = 1'b1;
    start_val = 4'd7;
    step(1);
    check("midrst_units", {28'd0, dut.units_q}, 32'd7);
    check("midrst_tens", {28'd0, dut.tens_q}, 32'd0);
    check("midrst_cnt", {25'd0, dut.tick_cnt_q}, 32'd0);
    check("midrst_an", {24'd0, an}, 32'hfe);
    check("midrst_seg", {25'd0, seg}, 32'b111_1000);
    check("midrst_dp1", {31'd0, dp1}, 32'd0);
    step(149);
    check("hold_rst_units", {28'd0, dut.units_q}, 32'd7);
    check("hold_rst_cnt", {25'd0, dut.tick_cnt_q}, 32'd0);

    // Carry 09 -> 10.
    start_val = 4'd9;
    step(1);
    rst = 1'b0;
    k = 0;
    goto(99);
    check("c9_units", {28'd0, dut.units_q}, 32'd9);
    goto(100);
    check("c10_units", {28'd0, dut.units_q}, 32'd0);
    check("c10_tens", {28'd0, dut.tens_q}, 32'd1);
    goto(105);
    check("c10_an_tens", {24'd0, an}, 32'hfd);
    check("c10_seg_tens", {25'd0, seg}, 32'b111_1001);
    goto(113);
    check("c10_an_units", {24'd0, an}, 32'hfe);
    check("c10_seg_units", {25'd0, seg}, 32'b100_0000);

    // Run to 99, then wrap to 00.
    goto(9000);
    check("c99_units", {28'd0, dut.units_q}, 32'd9);
    check("c99_tens", {28'd0, dut.tens_q}, 32'd9);
    goto(9001);
    check("c99_an", {24'd0, an}, 32'hfd);
    check("c99_seg", {25'd0, seg}, 32'b001_0000);
    goto(9100);
    check("wrap_units", {28'd0, dut.units_q}, 32'd0);
    check("wrap_tens", {28'd0, dut.tens_q}, 32'd0);
    goto(9105);
    check("wrap_an", {24'd0, an}, 32'hfe);
    check("wrap_seg", {25'd0, seg}, 32'b100_0000);

    // Non-BCD start values load as zero.
    rst = 1'b1;
    start_val = 4'd12;
    step(1);
    check("nbcd12_units", {28'd0, dut.units_q}, 32'd0);
    check("nbcd12_an", {24'd0, an}, 32'hfe);
    check("nbcd12_seg", {25'd0, seg}, 32'b100_0000);
    start_val = 4'd15;
    step(1);
    check("nbcd15_units", {28'd0, dut.units_q}, 32'd0);
    check("nbcd15_seg", {25'd0, seg}, 32'b100_0000);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
